// File: rtl/data_sram_axi_bridge_pkg.sv
// Shared AXI encodings and FSM state type for the data-side SRAM-to-AXI bridge.
package data_sram_axi_bridge_pkg;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;

    typedef enum logic [2:0] {
        IDLE,
        RD_A,
        RD_D,
        WR_AW,
        WR_B,
        DONE
    } state_t;

endpackage

// File: rtl/data_sram_axi_bridge_wen_to_axsize.sv
// Maps SRAM byte-write enables onto the AXI transfer size of a single-beat write.
module wen_to_axsize
    import data_sram_axi_bridge_pkg::*;
(
    input  logic [3:0] wen,
    output logic [2:0] axsize
);

    always_comb begin
        axsize = AXI_SIZE_4B;
        case (wen)
            4'b1111:                            axsize = AXI_SIZE_4B;
            4'b0011, 4'b1100:                   axsize = AXI_SIZE_2B;
            4'b0001, 4'b0010, 4'b0100, 4'b1000: axsize = AXI_SIZE_1B;
            default:                            axsize = AXI_SIZE_4B;
        endcase
    end

endmodule

// File: rtl/data_sram_axi_bridge.sv
// Converts one SRAM-like data request at a time into a single-beat AXI4 read or write,
// stalling the core until the response arrives and holding read data until it advances.
module data_sram_axi_bridge
    import data_sram_axi_bridge_pkg::*;
#(
    parameter int unsigned         ID_W   = 4,
    parameter logic [ID_W-1:0]     AXI_ID = ID_W'(1)
) (
    input  logic            clk,
    input  logic            resetn,

    input  logic            data_sram_en,
    input  logic [3:0]      data_sram_wen,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic [31:0]     data_sram_rdata,
    input  logic            pipeline_stall,
    output logic            data_stall,
    output logic            bus_err,

    output logic [ID_W-1:0] arid,
    output logic [31:0]     araddr,
    output logic [7:0]      arlen,
    output logic [2:0]      arsize,
    output logic [1:0]      arburst,
    output logic            arvalid,
    input  logic            arready,

    input  logic [ID_W-1:0] rid,
    input  logic [31:0]     rdata,
    input  logic [1:0]      rresp,
    input  logic            rlast,
    input  logic            rvalid,
    output logic            rready,

    output logic [ID_W-1:0] awid,
    output logic [31:0]     awaddr,
    output logic [7:0]      awlen,
    output logic [2:0]      awsize,
    output logic [1:0]      awburst,
    output logic            awvalid,
    input  logic            awready,

    output logic [ID_W-1:0] wid,
    output logic [31:0]     wdata,
    output logic [3:0]      wstrb,
    output logic            wlast,
    output logic            wvalid,
    input  logic            wready,

    input  logic [ID_W-1:0] bid,
    input  logic [1:0]      bresp,
    input  logic            bvalid,
    output logic            bready
);

    state_t      state_q, state_d;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wen_q;
    logic        aw_pend_q;
    logic        w_pend_q;
    logic [31:0] rdata_q;
    logic        bus_err_q;

    // Single-beat, in-order, one outstanding: response IDs and RLAST carry no information here.
    logic unused_resp_fields;
    assign unused_resp_fields = ^{rid, rlast, bid};

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_stall = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        awvalid    = 1'b0;
        wvalid     = 1'b0;
        bready     = 1'b0;
        case (state_q)
            IDLE: begin
                data_stall = data_sram_en;
                if (data_sram_en) begin
                    state_d = (data_sram_wen == 4'b0000) ? RD_A : WR_AW;
                end
            end
            RD_A: begin
                data_stall = 1'b1;
                arvalid    = 1'b1;
                if (arready) state_d = RD_D;
            end
            RD_D: begin
                data_stall = 1'b1;
                rready     = 1'b1;
                if (rvalid) state_d = DONE;
            end
            WR_AW: begin
                data_stall = 1'b1;
                awvalid    = aw_pend_q;
                wvalid     = w_pend_q;
                // Each channel is finished once its handshake has happened, now or earlier.
                if ((!aw_pend_q || awready) && (!w_pend_q || wready)) begin
                    state_d = WR_B;
                end
            end
            WR_B: begin
                data_stall = 1'b1;
                bready     = 1'b1;
                if (bvalid) state_d = DONE;
            end
            DONE: begin
                if (!pipeline_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wen_q     <= '0;
            aw_pend_q <= 1'b0;
            w_pend_q  <= 1'b0;
            rdata_q   <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            if (state_q == IDLE && data_sram_en) begin
                addr_q    <= data_sram_addr;
                wdata_q   <= data_sram_wdata;
                wen_q     <= data_sram_wen;
                aw_pend_q <= |data_sram_wen;
                w_pend_q  <= |data_sram_wen;
            end
            if (awvalid && awready) aw_pend_q <= 1'b0;
            if (wvalid && wready)   w_pend_q  <= 1'b0;
            if (state_q == RD_D && rvalid) begin
                rdata_q   <= rdata;
                bus_err_q <= (rresp != AXI_RESP_OKAY);
            end
            if (state_q == WR_B && bvalid) begin
                bus_err_q <= (bresp != AXI_RESP_OKAY);
            end
        end
    end

    wen_to_axsize u_wen_to_axsize (
        .wen    (wen_q),
        .axsize (awsize)
    );

    assign data_sram_rdata = rdata_q;
    assign bus_err         = bus_err_q;

    assign arid    = AXI_ID;
    assign araddr  = {addr_q[31:2], 2'b00};
    assign arlen   = '0;
    assign arsize  = AXI_SIZE_4B;
    assign arburst = AXI_BURST_INCR;

    assign awid    = AXI_ID;
    assign awaddr  = addr_q;
    assign awlen   = '0;
    assign awburst = AXI_BURST_INCR;

    assign wid     = AXI_ID;
    assign wdata   = wdata_q;
    assign wstrb   = wen_q;
    assign wlast   = 1'b1;

endmodule
